// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / load-store) front end for the single-port mainmem.
// One access in flight; sub-word stores are done as read-modify-write.
module mem_port_arbiter #(
  parameter logic [31:0] STARTING_ADDR   = 32'h0100_0000,
  parameter logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_data,
  output logic        if_resp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_wdata,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_data,
  output logic        d_resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_read_write
);

  localparam logic [31:0] LAST_WORD =
    STARTING_ADDR + MEM_DEPTH_BYTES - 32'd4;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic       GNT_IF = 1'b0;
  localparam logic       GNT_D  = 1'b1;

  typedef enum logic [2:0] {
    IDLE, RD, RMW_RD, WR, RESP
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, port_q;
  logic [31:0] addr_q, wdata_q, merge_q;
  logic [1:0]  size_q;

  logic        idle, if_win, d_win, accept;
  logic        req_we, req_bad;
  logic [31:0] req_addr, req_waddr;
  logic [1:0]  req_size;
  logic [4:0]  lane_sh;
  logic [31:0] size_mask, load_data, merged;
  logic        rsp_fire, rsp_port, rsp_err;
  logic [31:0] rsp_data;

  // Round-robin pick of the winner and legality check of its request
  always_comb begin
    idle   = (state_q == IDLE) && reset_n;
    if_win = idle && if_req_valid &&
             (!d_req_valid || last_grant_q == GNT_D);
    d_win  = idle && d_req_valid &&
             (!if_req_valid || last_grant_q == GNT_IF);
    accept    = if_win || d_win;
    req_addr  = d_win ? d_addr : if_addr;
    req_we    = d_win && d_we;
    req_size  = d_win ? d_size : SZ_W;
    req_waddr = {req_addr[31:2], 2'b00};
    req_bad   = (req_size == 2'b11) ||
                (req_size == SZ_H && req_addr[0]) ||
                (req_size == SZ_W && req_addr[1:0] != 2'b00) ||
                (req_waddr < STARTING_ADDR) ||
                (req_waddr > LAST_WORD);
  end

  assign if_req_ready = if_win;
  assign d_req_ready  = d_win;

  // Byte-lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    lane_sh = {addr_q[1:0], 3'b000};
    unique case (size_q)
      SZ_B:    size_mask = 32'h0000_00ff;
      SZ_H:    size_mask = 32'h0000_ffff;
      default: size_mask = 32'hffff_ffff;
    endcase
    load_data = (mem_data_out >> lane_sh) & size_mask;
    merged    = (mem_data_out & ~(size_mask << lane_sh)) |
                ((wdata_q & size_mask) << lane_sh);
  end

  // Which port gets a response strobe next cycle, and with what
  always_comb begin
    rsp_fire = (accept && req_bad) ||
               (state_q == RD) || (state_q == WR);
    rsp_port = accept ? d_win : port_q;
    rsp_err  = accept && req_bad;
    rsp_data = (state_q == RD) ? load_data : 32'h0;
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_bad)             state_d = RESP;
          else if (!req_we)        state_d = RD;
          else if (req_size == SZ_W) state_d = WR;
          else                     state_d = RMW_RD;
        end
      end
      RD:      state_d = RESP;
      RMW_RD:  state_d = WR;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory pin drive; the write strobe is gated by reset
  always_comb begin
    mem_address    = STARTING_ADDR;
    mem_data_in    = 32'h0;
    mem_read_write = 1'b0;
    unique case (state_q)
      RD, RMW_RD: mem_address = {addr_q[31:2], 2'b00};
      WR: begin
        mem_address    = {addr_q[31:2], 2'b00};
        mem_data_in    = (size_q == SZ_W) ? wdata_q : merge_q;
        mem_read_write = reset_n;
      end
      default: ;
    endcase
  end

  // Request latch, merge register and registered responses
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      last_grant_q  <= GNT_D;
      port_q        <= GNT_IF;
      addr_q        <= 32'h0;
      size_q        <= SZ_W;
      wdata_q       <= 32'h0;
      merge_q       <= 32'h0;
      if_resp_valid <= 1'b0;
      if_resp_data  <= 32'h0;
      if_resp_err   <= 1'b0;
      d_resp_valid  <= 1'b0;
      d_resp_data   <= 32'h0;
      d_resp_err    <= 1'b0;
    end else begin
      if (accept) begin
        last_grant_q <= d_win;
        port_q       <= d_win;
        addr_q       <= req_addr;
        size_q       <= req_size;
        wdata_q      <= d_win ? d_wdata : 32'h0;
      end
      if (state_q == RMW_RD) merge_q <= merged;
      if_resp_valid <= rsp_fire && !rsp_port;
      if_resp_err   <= rsp_fire && !rsp_port && rsp_err;
      if_resp_data  <= (rsp_fire && !rsp_port) ? rsp_data : 32'h0;
      d_resp_valid  <= rsp_fire && rsp_port;
      d_resp_err    <= rsp_fire && rsp_port && rsp_err;
      d_resp_data   <= (rsp_fire && rsp_port) ? rsp_data : 32'h0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus scoreboard of
// expected responses, with a small mainmem model.
module tb_mem_port_arbiter;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_req_valid, if_req_ready;
  logic [31:0] if_addr;
  logic        if_resp_valid, if_resp_err;
  logic [31:0] if_resp_data;
  logic        d_req_valid, d_req_ready, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [1:0]  d_size;
  logic        d_resp_valid, d_resp_err;
  logic [31:0] d_resp_data;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_read_write;

  always #5 clock = ~clock;

  mem_port_arbiter dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .if_req_valid   (if_req_valid),
    .if_req_ready   (if_req_ready),
    .if_addr        (if_addr),
    .if_resp_valid  (if_resp_valid),
    .if_resp_data   (if_resp_data),
    .if_resp_err    (if_resp_err),
    .d_req_valid    (d_req_valid),
    .d_req_ready    (d_req_ready),
    .d_addr         (d_addr),
    .d_we           (d_we),
    .d_size         (d_size),
    .d_wdata        (d_wdata),
    .d_resp_valid   (d_resp_valid),
    .d_resp_data    (d_resp_data),
    .d_resp_err     (d_resp_err),
    .mem_address    (mem_address),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .mem_read_write (mem_read_write)
  );

  // mainmem model: 256 words, combinational read, write at the edge
  logic [31:0] mem [0:255];
  logic        mem_ready = 1'b0;

  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[0]    <= 32'h0000_0093;
      mem[2]    <= 32'h8001_fffe;
      mem[4]    <= 32'h1122_3344;
      mem_ready <= 1'b1;
    end else if (mem_read_write) begin
      mem[mem_address[9:2]] <= mem_data_in;
    end
  end

  assign mem_data_out = mem[mem_address[9:2]];

  typedef struct {
    bit          port;
    logic [31:0] data;
    bit          err;
    int          due;
  } sb_t;

  typedef struct {
    bit          drop;
    logic [31:0] data;
    bit          err;
    int          lat;
  } exp_t;

  typedef struct {
    bit          port;
    logic [31:0] addr;
    bit          we;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] data;
    bit          err;
    int          lat;
    int          writes;
  } vec_t;

  sb_t  sb[$];
  bit   glog[$];
  exp_t if_exp, d_exp;
  sb_t  e;
  int   tests = 0;
  int   fails = 0;
  int   ncyc = 0;
  int   writes = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Response checker and grant recorder, sampled on the falling edge
  always @(negedge clock) begin
    ncyc++;
    if (mem_read_write === 1'b1) writes++;
    if (if_resp_valid || d_resp_valid) begin
      chk("one_resp", {31'b0, if_resp_valid & d_resp_valid}, 32'h0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got if=%0b d=%0b, expected none",
                 if_resp_valid, d_resp_valid);
      end else begin
        e = sb.pop_front();
        chk("resp_port", {31'b0, d_resp_valid}, {31'b0, e.port});
        chk("resp_data", d_resp_valid ? d_resp_data : if_resp_data,
            e.data);
        chk("resp_err", {31'b0, d_resp_valid ? d_resp_err : if_resp_err},
            {31'b0, e.err});
        chk("resp_cycle", ncyc, e.due);
      end
    end
    if (if_req_valid && if_req_ready) begin
      glog.push_back(1'b0);
      if (!if_exp.drop)
        sb.push_back('{1'b0, if_exp.data, if_exp.err, ncyc + if_exp.lat});
    end
    if (d_req_valid && d_req_ready) begin
      glog.push_back(1'b1);
      if (!d_exp.drop)
        sb.push_back('{1'b1, d_exp.data, d_exp.err, ncyc + d_exp.lat});
    end
  end

  task automatic wait_accept(input bit port);
    bit got = 1'b0;
    int t = 0;
    while (!got && t < 20) begin
      @(negedge clock);
      got = port ? (d_req_valid && d_req_ready)
                 : (if_req_valid && if_req_ready);
      t++;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got no ready, expected ready on port %0d",
               port);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(posedge clock);
      t++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    int w0;
    @(posedge clock);
    #1;
    w0 = writes;
    if (v.port) begin
      d_exp       = '{1'b0, v.data, v.err, v.lat};
      d_addr      = v.addr;
      d_we        = v.we;
      d_size      = v.size;
      d_wdata     = v.wdata;
      d_req_valid = 1'b1;
    end else begin
      if_exp       = '{1'b0, v.data, v.err, v.lat};
      if_addr      = v.addr;
      if_req_valid = 1'b1;
    end
    wait_accept(v.port);
    @(posedge clock);
    #1;
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    wait_drain();
    @(posedge clock);
    chk("write_count", writes - w0, v.writes);
  endtask

  vec_t vecs[18];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int w0;
    int t;
    vecs[0]  = '{0, BASE,             0, 2'd2, 32'h0,         32'h0000_0093, 0, 2, 0};
    vecs[1]  = '{1, BASE + 32'h12,    1, 2'd0, 32'h0000_00ab, 32'h0,         0, 3, 1};
    vecs[2]  = '{1, BASE + 32'h10,    0, 2'd2, 32'h0,         32'h11ab_3344, 0, 2, 0};
    vecs[3]  = '{1, BASE + 32'h0a,    0, 2'd1, 32'h0,         32'h0000_8001, 0, 2, 0};
    vecs[4]  = '{1, BASE + 32'h08,    0, 2'd0, 32'h0,         32'h0000_00fe, 0, 2, 0};
    vecs[5]  = '{1, BASE + 32'h01,    0, 2'd1, 32'h0,         32'h0,         1, 1, 0};
    vecs[6]  = '{1, 32'h00ff_fffc,    0, 2'd2, 32'h0,         32'h0,         1, 1, 0};
    vecs[7]  = '{1, 32'h0110_0000,    0, 2'd2, 32'h0,         32'h0,         1, 1, 0};
    vecs[8]  = '{1, BASE,             0, 2'd3, 32'h0,         32'h0,         1, 1, 0};
    vecs[9]  = '{1, BASE + 32'h0e,    1, 2'd1, 32'hffff_1234, 32'h0,         0, 3, 1};
    vecs[10] = '{1, BASE + 32'h0c,    0, 2'd2, 32'h0,         32'h1234_0000, 0, 2, 0};
    vecs[11] = '{1, BASE + 32'h14,    1, 2'd2, 32'hcafe_f00d, 32'h0,         0, 2, 1};
    vecs[12] = '{1, BASE + 32'h17,    0, 2'd0, 32'h0,         32'h0000_00ca, 0, 2, 0};
    vecs[13] = '{0, BASE + 32'h02,    0, 2'd2, 32'h0,         32'h0,         1, 1, 0};
    vecs[14] = '{1, 32'h010f_fffc,    0, 2'd2, 32'h0,         32'h0,         0, 2, 0};
    vecs[15] = '{1, BASE + 32'h01,    1, 2'd0, 32'h0000_0055, 32'h0,         0, 3, 1};
    vecs[16] = '{0, BASE,             0, 2'd2, 32'h0,         32'h0000_5593, 0, 2, 0};
    vecs[17] = '{1, BASE + 32'h22,    1, 2'd2, 32'h1234_5678, 32'h0,         1, 1, 0};

    if_exp       = '{1'b1, 32'h0, 1'b0, 0};
    d_exp        = '{1'b1, 32'h0, 1'b0, 0};
    reset_n      = 1'b0;
    if_req_valid = 1'b1;
    d_req_valid  = 1'b1;
    if_addr      = BASE;
    d_addr       = BASE;
    d_we         = 1'b0;
    d_size       = 2'd2;
    d_wdata      = 32'h0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_if_ready", {31'b0, if_req_ready}, 32'h0);
    chk("rst_d_ready", {31'b0, d_req_ready}, 32'h0);
    chk("rst_if_valid", {31'b0, if_resp_valid}, 32'h0);
    chk("rst_d_valid", {31'b0, d_resp_valid}, 32'h0);
    chk("rst_if_data", if_resp_data, 32'h0);
    chk("rst_d_data", d_resp_data, 32'h0);
    chk("rst_mem_addr", mem_address, BASE);
    chk("rst_mem_din", mem_data_in, 32'h0);
    chk("rst_mem_rw", {31'b0, mem_read_write}, 32'h0);
    @(posedge clock);
    #1;
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    reset_n      = 1'b1;

    // Both ports held valid: grants must alternate starting with IF
    @(posedge clock);
    #1;
    glog.delete();
    if_exp       = '{1'b0, 32'h0000_0093, 1'b0, 2};
    d_exp        = '{1'b0, 32'h8001_fffe, 1'b0, 2};
    if_addr      = BASE;
    d_addr       = BASE + 32'h08;
    d_we         = 1'b0;
    d_size       = 2'd2;
    if_req_valid = 1'b1;
    d_req_valid  = 1'b1;
    t = 0;
    while (glog.size() < 6 && t < 100) begin
      @(posedge clock);
      t++;
    end
    #1;
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    wait_drain();
    chk("rr_count", glog.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < glog.size())
        chk("rr_grant", {31'b0, glog[i]}, i % 2);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset asserted for the whole WR cycle of a word store
    @(posedge clock);
    #1;
    w0          = writes;
    d_exp       = '{1'b1, 32'h0, 1'b0, 0};
    d_addr      = BASE + 32'h20;
    d_we        = 1'b1;
    d_size      = 2'd2;
    d_wdata     = 32'hdead_beef;
    d_req_valid = 1'b1;
    wait_accept(1'b1);
    @(posedge clock);
    #1;
    d_req_valid = 1'b0;
    reset_n     = 1'b0;
    @(negedge clock);
    chk("rstwr_rw", {31'b0, mem_read_write}, 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("rstwr_d_valid", {31'b0, d_resp_valid}, 32'h0);
    chk("rstwr_d_err", {31'b0, d_resp_err}, 32'h0);
    chk("rstwr_d_data", d_resp_data, 32'h0);
    chk("rstwr_if_valid", {31'b0, if_resp_valid}, 32'h0);
    chk("rstwr_mem_addr", mem_address, BASE);
    chk("rstwr_mem_din", mem_data_in, 32'h0);
    repeat (4) @(posedge clock);
    chk("rstwr_writes", writes - w0, 0);
    run_vec('{1, BASE + 32'h20, 0, 2'd2, 32'h0, 32'h0, 0, 2, 0});

    repeat (2) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port controller in front of the single-port `mainmem`: it arbitrates between the instruction-fetch port and the load/store data port, sequences every access onto the memory's `address` / `data_in` / `read_write` / `data_out` pins, and returns responses.

- Sub-word stores are implemented as read-modify-write, since `mainmem` only writes whole little-endian words.
- Sits between the core's IF/LSU stages and `mainmem`.

## Interface
- `STARTING_ADDR`, default `'h01000000`: base byte address of memory.
- `MEM_DEPTH_BYTES`, default `'h0100000`: memory size in bytes.
- `clock` in 1: single clock. One clock; reset is synchronous and active-low.
- `reset_n` in 1: synchronous, active-low reset.
- `if_req_valid` in 1: fetch request.
- `if_req_ready` out 1: fetch request accepted this cycle.
- `if_addr` in 32: fetch byte address.
- `if_resp_valid` out 1: one-cycle fetch response strobe.
- `if_resp_data` out 32: fetched word.
- `if_resp_err` out 1: fetch fault.
- `d_req_valid` in 1: data request.
- `d_req_ready` out 1: data request accepted.
- `d_addr` in 32: data byte address.
- `d_we` in 1: 1 = store, 0 = load.
- `d_size` in 2: 00 byte, 01 half, 10 word; 11 is illegal and reported as an error.
- `d_wdata` in 32: store data, right-aligned.
- `d_resp_valid` out 1: one-cycle data response/ack strobe.
- `d_resp_data` out 32: load data, right-aligned and zero-extended; 0 for stores and errors.
- `d_resp_err` out 1: data fault.
- `mem_address` out 32: to `mainmem.address`.
- `mem_data_in` out 32: to `mainmem.data_in`.
- `mem_data_out` in 32: from `mainmem.data_out` (combinational read).
- `mem_read_write` out 1: to `mainmem.read_write`; 0 = READ, 1 = WRITE.

## Operation
- **States:** IDLE, RD, RMW_RD, WR, RESP. Only one request is in flight at a time.

**Arbitration (IDLE only)**
- A single pending request is granted immediately.
- When both ports are pending, the port not granted last time wins.
- `last_grant` resets to DATA, so IF wins the first tie.
- `if_req_ready` / `d_req_ready` are combinational and high only in IDLE, only for the winner.
- A transfer occurs on `valid && ready`. Requesters hold valid and payload until accepted.

**Accept**
- On accept, latch `addr`, `we`, `size`, `wdata`, and the port ID.
- Check the request:
  - alignment: half needs `addr[0]` = 0; word needs `addr[1:0]` = 0.
  - range: word address (`addr & ~3`) must lie in [`STARTING_ADDR`, `STARTING_ADDR + MEM_DEPTH_BYTES − 4`].
  - `d_size` = 11 is illegal.
- A failing request goes straight to RESP with err = 1 and data = 0, and makes no memory access.
- IF requests are always word-size loads.

**Next state for a legal request**
- Load → RD.
- Word store → WR.
- Byte/half store → RMW_RD.

**Memory-side actions**
- RD:
  - Drive the word-aligned address with READ.
  - At the edge, capture `mem_data_out`, shifted right by `8*addr[1:0]` and masked to size.
  - Go to RESP.
- RMW_RD:
  - Read the word.
  - At the edge, merge `wdata` into the byte lanes selected by `addr[1:0]` / `size` and hold the result in the merge register.
  - Go to WR.
- WR:
  - Drive the aligned address, the word data (`wdata` or the merge register), and `mem_read_write` = WRITE.
  - `mainmem` commits at the edge.
  - Go to RESP.
- RESP:
  - The requester's `resp_valid` is high for exactly one cycle, with data and err.
  - Go to IDLE.

**Memory pins outside RD/RMW_RD/WR**
- `mem_address` = `STARTING_ADDR`, `mem_data_in` = 0, `mem_read_write` = READ.
- `mem_read_write` = WRITE only when state is WR and `reset_n` = 1, i.e. combinationally gated by reset.

## Timing
- Accept at edge E0. Response strobe:
  - load: E1→E2
  - word store: E1→E2
  - sub-word store: E2→E3
  - error: E0→E1
- The memory write commits at the WR-exit edge.
- The next accept is no earlier than the edge that ends RESP. Throughput is 1 access per 3 cycles for loads and word stores, and 1 per 4 for sub-word stores.
- Response outputs are registered; `resp_valid` never asserts on both ports in the same cycle.
- **Reset values** (`reset_n` = 0 at an edge):
  - state IDLE
  - all `resp_valid` / `resp_err` 0; all `resp_data` 0
  - `last_grant` DATA
  - `mem_address` `STARTING_ADDR`, `mem_data_in` 0, `mem_read_write` READ
- **Reset during WR:** no write reaches memory, because of the gating.
- **Reset during RD or RMW_RD:** the access is discarded and no response is issued.
- **Requests during reset:** `valid` high during reset is not accepted; both `ready` outputs are 0 while `reset_n` = 0.
- **Simultaneous requests:**
  - A request arriving while busy waits and is arbitrated at the next IDLE cycle.
  - If both ports arrive at once, they alternate strictly.

## Test plan
- **IF word load:** memory word 0 = 32'h00000093. IF fetch at 'h01000000 → `if_resp_data` = 32'h00000093, err = 0, `if_resp_valid` exactly 2 cycles after accept and high for 1 cycle.
- **Byte store (RMW):** memory 'h01000010 = 32'h11223344. Store byte 8'hAB at 'h01000012, then word load at 'h01000010 → 32'h11AB3344. Store ack comes 3 cycles after accept, and exactly one WRITE cycle is seen on `mem_read_write`.
- **Faults:**
  - Half load at 'h01000001 → `d_resp_err` = 1, data 0, 1-cycle latency, `mem_read_write` never 1.
  - Word load at 'h00FFFFFC → err.
  - Word load at `STARTING_ADDR + MEM_DEPTH_BYTES` → err.
- **Round-robin:** both ports valid continuously for 6 grants, first grant out of reset → grant order IF, D, IF, D, IF, D; `d_resp_valid` and `if_resp_valid` are never high together.
- **Reset during WR:** word store of 32'hDEADBEEF to 'h01000020 (old value 32'h0), `reset_n` low during the WR cycle → a later load returns 32'h0, no ack is issued, and all outputs are at their reset values after the edge.
- **Half load extraction:** memory 'h01000008 = 32'h8001FFFE. Half load at 'h0100000A → 32'h00008001 (zero-extended). Byte load at 'h01000008 → 32'h000000FE.
